// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: deserialises {cmd[1:0], byte} frames
// from MOSI and shifts the RAM read byte back out on MISO, one bit per clk edge.
module spi_slave_if #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int unsigned RX_W       = DATA_W + 2;
    localparam int unsigned FRAME_BITS = DATA_W + 1;
    localparam int unsigned CNT_W      = $clog2(RX_W);
    localparam int unsigned TX_CNT_W   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_idx_c;
    logic                 shift_en_c;
    logic                 frame_last_c;
    logic                 tx_load_c;
    logic                 rd_addr_seen;
    logic [DATA_W-1:0]    tx_sr;
    logic [TX_CNT_W-1:0]  tx_cnt;
    logic                 tx_busy;
    logic                 tx_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-edge control strobes
    always_comb begin
        state_next   = state;
        shift_en_c   = 1'b0;
        frame_last_c = 1'b0;
        tx_load_c    = 1'b0;
        bit_idx_c    = CNT_W'(FRAME_BITS - 1) - bit_cnt;
        case (state)
            IDLE: begin
                state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (!MOSI) begin
                    state_next = WRITE;
                end else if (rd_addr_seen) begin
                    state_next = READ_DATA;
                end else begin
                    state_next = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                shift_en_c   = (bit_cnt != CNT_W'(FRAME_BITS));
                frame_last_c = (bit_cnt == CNT_W'(FRAME_BITS - 1));
                tx_load_c    = (state == READ_DATA) && (bit_cnt == CNT_W'(FRAME_BITS))
                               && tx_valid && !tx_busy && !tx_done;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (SS_n) begin
            state_next   = IDLE;
            shift_en_c   = 1'b0;
            frame_last_c = 1'b0;
            tx_load_c    = 1'b0;
        end
    end

    // Frame assembly, read-address flag and MISO serialiser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
            bit_cnt      <= '0;
            rd_addr_seen <= 1'b0;
            tx_sr        <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            MISO     <= 1'b0;
            if (SS_n) begin
                bit_cnt <= '0;
                tx_sr   <= '0;
                tx_cnt  <= '0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
            end else begin
                if (state == CHK_CMD) begin
                    rx_data[RX_W-1] <= MOSI;
                end
                if (shift_en_c) begin
                    rx_data[bit_idx_c] <= MOSI;
                    bit_cnt            <= bit_cnt + CNT_W'(1);
                    if (frame_last_c) begin
                        rx_valid <= 1'b1;
                        if (state == READ_ADD) begin
                            rd_addr_seen <= 1'b1;
                        end
                    end
                end
                if (tx_load_c) begin
                    tx_sr   <= tx_data;
                    tx_cnt  <= '0;
                    tx_busy <= 1'b1;
                end else if (tx_busy) begin
                    MISO   <= tx_sr[DATA_W-1];
                    tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                    tx_cnt <= tx_cnt + TX_CNT_W'(1);
                    if (tx_cnt == TX_CNT_W'(DATA_W - 1)) begin
                        tx_busy      <= 1'b0;
                        tx_done      <= 1'b1;
                        rd_addr_seen <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write, read-address/read-data, abort,
// over-long frame and asynchronous reset during the MISO shift.
module tb_spi_slave_if;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int miso_hi     = 0;
    int p0;
    int m0;
    logic [7:0] rd_byte;

    spi_slave_if #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles and MISO-high cycles, sampled before each edge updates them
    always @(posedge clk) begin
        if (rx_valid === 1'b1) pulses++;
        if (MISO === 1'b1) miso_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Select, then ten bits MSB first; returns at the negedge after the 11th edge
    task automatic frame(input logic [9:0] f);
        SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            MOSI = f[i];
            tick();
        end
        MOSI = 1'b0;
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h000);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_miso", 32'(MISO), 32'h0);
        check("reset_rd_addr_seen", 32'(dut.rd_addr_seen), 32'h0);
        rst_n = 1'b1;
        tick();

        // Write address
        p0 = pulses;
        m0 = miso_hi;
        frame(10'h005);
        check("wa_rx_valid", 32'(rx_valid), 32'h1);
        check("wa_rx_data", 32'(rx_data), 32'h005);
        tick();
        check("wa_rx_valid_drop", 32'(rx_valid), 32'h0);
        end_frame();
        check("wa_pulses", 32'(pulses - p0), 32'd1);
        check("wa_miso_quiet", 32'(miso_hi - m0), 32'd0);
        check("wa_rd_addr_seen", 32'(dut.rd_addr_seen), 32'h0);

        // Write data
        p0 = pulses;
        frame(10'h1A5);
        check("wd_rx_data", 32'(rx_data), 32'h1A5);
        end_frame();
        check("wd_pulses", 32'(pulses - p0), 32'd1);

        // Read address
        frame(10'h205);
        check("ra_rx_data", 32'(rx_data), 32'h205);
        tick();
        check("ra_rd_addr_seen", 32'(dut.rd_addr_seen), 32'h1);
        end_frame();

        // Read data; tx_valid asserted during the frame must be ignored
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        frame(10'h3C3);
        check("rd_rx_valid", 32'(rx_valid), 32'h1);
        check("rd_rx_data", 32'(rx_data), 32'h3C3);
        tx_valid = 1'b0;
        tick();
        check("rd_miso_idle", 32'(MISO), 32'h0);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        check("rd_miso_latch", 32'(MISO), 32'h0);
        rd_byte = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            tick();
            check($sformatf("rd_miso_bit%0d", i), 32'(MISO), 32'(rd_byte[i]));
        end
        tick();
        check("rd_miso_after", 32'(MISO), 32'h0);
        tick();
        check("rd_miso_no_reload", 32'(MISO), 32'h0);
        check("rd_rd_addr_cleared", 32'(dut.rd_addr_seen), 32'h0);
        tx_valid = 1'b0;
        end_frame();

        // Abort after 6 bits of a write, then a clean frame
        p0 = pulses;
        SS_n = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            MOSI = (i >= 2) ? 1'b1 : 1'b0;
            tick();
        end
        end_frame();
        check("ab_rx_valid", 32'(rx_valid), 32'h0);
        tick();
        check("ab_pulses", 32'(pulses - p0), 32'd0);
        p0 = pulses;
        frame(10'h0F0);
        check("ab_next_rx_valid", 32'(rx_valid), 32'h1);
        check("ab_next_rx_data", 32'(rx_data), 32'h0F0);
        end_frame();
        check("ab_next_pulses", 32'(pulses - p0), 32'd1);

        // Over-long frame: 14 bits, only the first 10 count
        p0 = pulses;
        frame(10'h0C3);
        check("ol_rx_data", 32'(rx_data), 32'h0C3);
        for (int i = 0; i < 4; i++) begin
            MOSI = 1'b1;
            tick();
        end
        MOSI = 1'b0;
        check("ol_rx_data_hold", 32'(rx_data), 32'h0C3);
        end_frame();
        check("ol_pulses", 32'(pulses - p0), 32'd1);

        // Asynchronous reset in the middle of a READ_DATA shift
        frame(10'h211);
        end_frame();
        check("rs_rd_addr_seen", 32'(dut.rd_addr_seen), 32'h1);
        frame(10'h3FF);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tick();
        check("rs_miso_shifting", 32'(MISO), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_miso", 32'(MISO), 32'h0);
        check("rs_rx_valid", 32'(rx_valid), 32'h0);
        check("rs_rx_data", 32'(rx_data), 32'h000);
        check("rs_rd_addr_cleared", 32'(dut.rd_addr_seen), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        SS_n     = 1'b1;
        tick();
        frame(10'h201);
        check("rs_next_rx_data", 32'(rx_data), 32'h201);
        tick();
        check("rs_next_read_add", 32'(dut.rd_addr_seen), 32'h1);
        end_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front end that sits directly upstream of the single-port sync RAM.
- Deserialises MOSI frames into 10-bit command/data words {cmd[1:0], byte[7:0]} and hands them to the RAM on rx_data/rx_valid.
- Serialises the RAM read byte (tx_data/tx_valid) back onto MISO.
- SPI bit clock equals the system clock: one MOSI/MISO bit per rising edge of clk.

Parameters:
- DATA_W, 8, payload width; rx_data is DATA_W+2 bits, tx_data is DATA_W bits.

Ports:
- clk  input  1  system clock; all sampling on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  slave select, active low; a frame runs while low.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  DATA_W+2  assembled frame to the RAM.
- rx_valid  output  1  one-cycle strobe qualifying rx_data.
- tx_data  input  DATA_W  read byte from the RAM.
- tx_valid  input  1  tx_data valid (level).

Behaviour:
- Reset (rst_n=0, async): state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_seen=0, tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: if SS_n=0 at an edge, go to CHK_CMD. MOSI is ignored on this edge.
- CHK_CMD: the edge samples MOSI as rx_data[9].
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: the next 9 edges shift MOSI into rx_data[8:0], MSB first. rx_data is built in place, and the completed frame holds until the next frame's CHK_CMD edge.
- rx_valid: registered; high for exactly one cycle, in the cycle after the edge that samples bit 0. Latency from SS_n fall to rx_valid is 11 edges.
- Bits beyond the 10th in a frame: ignored; no further rx_valid until SS_n rises and falls again.
- rd_addr_seen:
  - Set when a READ_ADD frame completes (rx_valid issued).
  - Cleared when a READ_DATA frame completes its 8-bit MISO transfer.
  - A WRITE frame does not change it.
- READ_DATA output phase, after rx_valid:
  - Wait for tx_valid=1. On the first edge where it is seen, latch tx_data into the shift register.
  - On the following DATA_W edges, MISO is driven registered with bits DATA_W-1..0, one per edge.
  - MISO then returns to 0 and the state holds until SS_n=1.
  - tx_valid seen before rx_valid has been issued is ignored.
- MISO is 0 in every state except the READ_DATA output phase.
- SS_n=1 at any edge, in any state: next state IDLE; bit counter and shift register cleared; rx_valid forced 0; MISO=0.
  - A partial frame produces no rx_valid.
  - rd_addr_seen is unchanged, so an aborted READ_DATA keeps the flag set.
- Reset mid-frame: immediate return to reset values. rd_addr_seen is cleared.
- SS_n going low while rx_valid is high: the strobe still completes its single cycle.

Test Plan:
- Write address: SS_n low, MOSI 00_0000_0101 -> one rx_valid pulse, rx_data=0x005, MISO stays 0, rd_addr_seen=0.
- Write data: frame 01_1010_0101 -> rx_data=0x1A5, single rx_valid.
- Read address then data:
  - Frame 10_0000_0101 -> rx_data=0x205, rd_addr_seen=1.
  - Next frame 11_xxxx_xxxx -> state goes to READ_DATA, rx_data=0x3xx.
  - Drive tx_valid=1 with tx_data=0xA5 one cycle after rx_valid -> MISO sequence 1,0,1,0,0,1,0,1 on the 8 following edges, then 0.
  - rd_addr_seen=0 afterwards.
- Abort: raise SS_n after 6 bits of a WRITE frame -> no rx_valid, state=IDLE; the next full frame decodes correctly.
- Over-long frame: 14 bits with SS_n low -> exactly one rx_valid, carrying the first 10 bits.
- Async reset mid-READ_DATA shift: drop rst_n between edges -> MISO=0, rx_valid=0 immediately; the next frame starting with 1 goes to READ_ADD.
